// File: rtl/peripheral_bus.sv
// Memory-mapped I/O responder at 0x4000_0000: interval timer with IRQ, LEDs, switches, 7-seg, systick.
// Latency: reads are combinational (zero cycles); writes land at the rising edge and are visible the next cycle.
// Backpressure: none; every bus access completes in the cycle it is issued.
module peripheral_bus (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH  = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI    = 32'h4000_0014;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0018;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] systick_q, systick_d;

  logic ovf;
  logic ovf_irq;

  // Overflow is an enabled timer sitting at all-ones; it only latches status when interrupts are enabled.
  assign ovf     = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
  assign ovf_irq = ovf && tcon_q[1];

  // Next-state: timer advance first, then CPU writes override (TCON status bit is sticky against a colliding write).
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;

    if (tcon_q[0]) begin
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end
    if (ovf_irq) begin
      tcon_d[2] = 1'b1;
    end

    if (wr) begin
      if (addr == ADDR_TH)   th_d   = wdata;
      if (addr == ADDR_TL)   tl_d   = wdata;
      if (addr == ADDR_TCON) tcon_d = wdata[2:0] | {ovf_irq, 2'b00};
      if (addr == ADDR_LED)  led_d  = wdata[7:0];
      if (addr == ADDR_DIGI) digi_d = wdata[11:0];
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
    end
  end

  // Combinational read mux; shows pre-write state when rd and wr collide.
  always_comb begin
    rdata = '0;
    if (rd) begin
      case (addr)
        ADDR_TH:      rdata = th_q;
        ADDR_TL:      rdata = tl_q;
        ADDR_TCON:    rdata = {29'd0, tcon_q};
        ADDR_LED:     rdata = {24'd0, led_q};
        ADDR_SWITCH:  rdata = {24'd0, switch};
        ADDR_DIGI:    rdata = {20'd0, digi_q};
        ADDR_SYSTICK: rdata = systick_q;
        default:      rdata = '0;
      endcase
    end
  end

  assign led  = led_q;
  assign digi = digi_q;
  assign irq  = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_peripheral_bus.sv
// Self-checking bench for peripheral_bus: register map table plus timer/collision/reset sequences.
// Latency: inputs change on the falling edge, outputs sampled 1 time unit later.
// Backpressure: not applicable.
module tb_peripheral_bus;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_TICK = 32'h4000_0018;
  localparam logic [31:0] A_NONE = 32'h4000_001C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  switch = 8'hA5;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  int pass_cnt = 0;
  int total_cnt = 0;

  peripheral_bus dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .switch (switch),
    .led    (led),
    .digi   (digi),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  sw;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_led;
    logic [11:0] exp_digi;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // One bus cycle: drive on the falling edge, settle, caller checks afterwards.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, A_TH,   32'h0,         8'hA5, 32'h0,    8'h00, 12'h000};
    vecs[1]  = '{1'b1, 1'b0, A_TL,   32'h0,         8'hA5, 32'h0,    8'h00, 12'h000};
    vecs[2]  = '{1'b1, 1'b0, A_TCON, 32'h0,         8'hA5, 32'h0,    8'h00, 12'h000};
    vecs[3]  = '{1'b1, 1'b0, A_LED,  32'h0,         8'hA5, 32'h0,    8'h00, 12'h000};
    vecs[4]  = '{1'b1, 1'b0, A_SW,   32'h0,         8'hA5, 32'hA5,   8'h00, 12'h000};
    vecs[5]  = '{1'b1, 1'b0, A_DIGI, 32'h0,         8'h5A, 32'h0,    8'h00, 12'h000};
    vecs[6]  = '{1'b0, 1'b1, A_LED,  32'hFFFF_FF3C, 8'h5A, 32'h0,    8'h00, 12'h000};
    vecs[7]  = '{1'b1, 1'b1, A_DIGI, 32'hFFFF_F7E1, 8'h5A, 32'h0,    8'h3C, 12'h000};
    vecs[8]  = '{1'b1, 1'b0, A_LED,  32'h0,         8'h5A, 32'h3C,   8'h3C, 12'h7E1};
    vecs[9]  = '{1'b1, 1'b0, A_DIGI, 32'h0,         8'h5A, 32'h7E1,  8'h3C, 12'h7E1};
    vecs[10] = '{1'b1, 1'b0, A_SW,   32'h0,         8'h5A, 32'h5A,   8'h3C, 12'h7E1};
    vecs[11] = '{1'b0, 1'b1, A_SW,   32'hFFFF_FFFF, 8'h5A, 32'h0,    8'h3C, 12'h7E1};
    vecs[12] = '{1'b0, 1'b1, A_TICK, 32'h0,         8'h5A, 32'h0,    8'h3C, 12'h7E1};
    vecs[13] = '{1'b0, 1'b1, A_NONE, 32'hFFFF_FFFF, 8'h5A, 32'h0,    8'h3C, 12'h7E1};
    vecs[14] = '{1'b1, 1'b0, A_NONE, 32'h0,         8'h5A, 32'h0,    8'h3C, 12'h7E1};
    vecs[15] = '{1'b0, 1'b0, A_LED,  32'h0,         8'h5A, 32'h0,    8'h3C, 12'h7E1};
    vecs[16] = '{1'b1, 1'b0, 32'h4000_0001, 32'h0,  8'h5A, 32'h0,    8'h3C, 12'h7E1};

    // Reset held, then released away from any rising edge.
    repeat (2) @(negedge clk);
    #1;
    check("irq_in_reset", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rd = 1'b1; addr = A_TICK;
    #1;
    check("systick_at_release", rdata, 32'd0);
    step(1'b1, 1'b0, A_TICK, 32'h0);
    check("systick_1", rdata, 32'd1);
    step(1'b1, 1'b0, A_TICK, 32'h0);
    check("systick_2", rdata, 32'd2);

    // Register map table.
    foreach (vecs[i]) begin
      @(negedge clk);
      rd = vecs[i].r; wr = vecs[i].w; addr = vecs[i].a; wdata = vecs[i].d; switch = vecs[i].sw;
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, vecs[i].exp_led});
      check($sformatf("vec%0d_digi", i), {20'd0, digi}, {20'd0, vecs[i].exp_digi});
    end
    step(1'b1, 1'b0, A_TH, 32'h0);
    check("th_untouched", rdata, 32'h0);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_untouched", rdata, 32'h0);

    // Timer: reload FFFF_FFFC, period 4 with interrupts.
    step(1'b0, 1'b1, A_TH, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, A_TL, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, A_TCON, 32'h3);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_start", rdata, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_fd", rdata, 32'hFFFF_FFFD);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_fe", rdata, 32'hFFFF_FFFE);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_ff", rdata, 32'hFFFF_FFFF);
    check("irq_before_wrap", {31'd0, irq}, 32'd0);
    step(1'b1, 1'b1, A_TCON, 32'h3);
    check("tcon_pending", rdata, 32'h7);
    check("irq_after_wrap", {31'd0, irq}, 32'd1);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_after_ack", rdata, 32'hFFFF_FFFD);
    check("irq_acked", {31'd0, irq}, 32'd0);
    step(1'b1, 1'b0, A_TL, 32'h0);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("irq_pre_second", {31'd0, irq}, 32'd0);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_second_wrap", rdata, 32'hFFFF_FFFC);
    check("irq_second", {31'd0, irq}, 32'd1);

    // TCON write colliding with overflow keeps the pending status.
    step(1'b0, 1'b0, A_TL, 32'h0);
    step(1'b0, 1'b0, A_TL, 32'h0);
    step(1'b0, 1'b1, A_TCON, 32'h3);
    step(1'b1, 1'b0, A_TCON, 32'h0);
    check("tcon_collision", rdata, 32'h7);
    check("irq_collision", {31'd0, irq}, 32'd1);

    // TL write colliding with overflow wins over reload.
    step(1'b0, 1'b0, A_TL, 32'h0);
    step(1'b0, 1'b0, A_TL, 32'h0);
    step(1'b1, 1'b1, A_TL, 32'h0000_1234);
    check("tl_ff_before_write", rdata, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_write_wins", rdata, 32'h0000_1234);

    // Interrupts disabled: overflow reloads but raises nothing.
    step(1'b0, 1'b1, A_TCON, 32'h1);
    step(1'b0, 1'b1, A_TL, 32'hFFFF_FFFE);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_fe_noint", rdata, 32'hFFFF_FFFE);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_ff_noint", rdata, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_reload_noint", rdata, 32'hFFFF_FFFC);
    check("irq_noint", {31'd0, irq}, 32'd0);
    step(1'b1, 1'b0, A_TCON, 32'h0);
    check("tcon_noint", rdata, 32'h1);

    // Reset while running with irq asserted.
    step(1'b0, 1'b1, A_TCON, 32'h3);
    step(1'b0, 1'b0, A_TL, 32'h0);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("irq_before_reset", {31'd0, irq}, 32'd1);
    reset = 1'b0;
    #1;
    check("irq_async_reset", {31'd0, irq}, 32'd0);
    check("led_async_reset", {24'd0, led}, 32'd0);
    check("digi_async_reset", {20'd0, digi}, 32'd0);
    check("tl_async_reset", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, A_TL, 32'h0);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_stays_zero", rdata, 32'd0);
    step(1'b1, 1'b1, A_TCON, 32'h1);
    check("tcon_after_reset", rdata, 32'd0);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_restart_0", rdata, 32'd0);
    step(1'b1, 1'b0, A_TL, 32'h0);
    check("tl_restart_1", rdata, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
